run_monitor: RTL and testbench

RUN_MONITOR -- requirements
Module: run_monitor

---
 rtl/run_monitor.sv | 170 +++++++++++++++++
 tb/tb_run_monitor.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_monitor.sv
// run_monitor: watches a processor's retirement stream and reports whether a
// test program halted (self-loop at one PC) or failed (cycle timeout, or a
// retirement stall when the optional watchdog is built in).
// Optional feature macro: RUN_MONITOR_STALL_EN enables the stall watchdog.
module run_monitor #(
  parameter int unsigned PC_W           = 32,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000000000,
  parameter int unsigned STALL_LIMIT    = 1024,
  parameter int unsigned HALT_REPEAT    = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_clear,
  input  logic             i_insn_vld,
  input  logic [PC_W-1:0]  i_pc_debug,
  output logic [1:0]       o_state,
  output logic             o_done,
  output logic             o_pass,
  output logic             o_timeout,
  output logic             o_stall,
  output logic [CNT_W-1:0] o_cycle_count,
  output logic [CNT_W-1:0] o_insn_count,
  output logic [PC_W-1:0]  o_last_pc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  localparam int unsigned RPT_W   = $clog2(HALT_REPEAT + 1);
  localparam logic [63:0] TO_LAST = 64'(TIMEOUT_CYCLES) - 64'd1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]   insn_q, insn_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [RPT_W-1:0]   rpt_q, rpt_d;
  logic               seen_q, seen_d;
  logic               to_q, to_d;

  logic               in_run;
  logic               start_run;
  logic [RPT_W-1:0]   rpt_inc;
  logic               halt_hit;
  logic               to_hit;
  logic               stall_hit;

  // Event decode shared by the main FSM and the stall watchdog
  always_comb begin
    in_run    = (state_q == S_RUN);
    start_run = (state_q == S_IDLE) && i_start && !i_clear;
    // The first retirement after start never counts as a repeat, even when
    // its PC happens to equal the zeroed last-PC register.
    rpt_inc   = (seen_q && (i_pc_debug == pc_q)) ? rpt_q + RPT_W'(1) : RPT_W'(1);
    halt_hit  = in_run && i_insn_vld && (rpt_inc == RPT_W'(HALT_REPEAT));
    to_hit    = in_run && (64'(cyc_q) == TO_LAST);
  end

  // Next-state and counter update; priority HALT > timeout > stall
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    insn_d  = insn_q;
    pc_d    = pc_q;
    rpt_d   = rpt_q;
    seen_d  = seen_q;
    to_d    = to_q;
    if (i_clear || start_run) begin
      state_d = i_clear ? S_IDLE : S_RUN;
      cyc_d   = '0;
      insn_d  = '0;
      pc_d    = '0;
      rpt_d   = '0;
      seen_d  = 1'b0;
      to_d    = 1'b0;
    end else if (in_run) begin
      cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);
      if (i_insn_vld) begin
        insn_d = (insn_q == '1) ? insn_q : insn_q + CNT_W'(1);
        pc_d   = i_pc_debug;
        rpt_d  = rpt_inc;
        seen_d = 1'b1;
      end
      if (halt_hit) begin
        state_d = S_HALT;
      end else if (to_hit) begin
        state_d = S_FAIL;
        to_d    = 1'b1;
      end else if (stall_hit) begin
        state_d = S_FAIL;
      end
    end
  end

  // Main state and counter registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      insn_q  <= '0;
      pc_q    <= '0;
      rpt_q   <= '0;
      seen_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      insn_q  <= insn_d;
      pc_q    <= pc_d;
      rpt_q   <= rpt_d;
      seen_q  <= seen_d;
      to_q    <= to_d;
    end
  end

`ifdef RUN_MONITOR_STALL_EN
  localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               stall_q, stall_d;

  assign stall_hit = in_run && !i_insn_vld &&
                     (stall_cnt_q == STALL_W'(STALL_LIMIT - 1));

  // Idle-cycle counter; only raises its flag when no higher cause fires
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    stall_d     = stall_q;
    if (i_clear || start_run) begin
      stall_cnt_d = '0;
      stall_d     = 1'b0;
    end else if (in_run) begin
      stall_cnt_d = i_insn_vld ? '0 : stall_cnt_q + STALL_W'(1);
      if (stall_hit && !halt_hit && !to_hit) begin
        stall_d = 1'b1;
      end
    end
  end

  // Stall watchdog registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      stall_q     <= stall_d;
    end
  end

  assign o_stall = stall_q;
`else
  assign stall_hit = 1'b0;
  assign o_stall   = 1'b0;
`endif

  assign o_state       = state_q;
  assign o_done        = (state_q == S_HALT) || (state_q == S_FAIL);
  assign o_pass        = (state_q == S_HALT);
  assign o_timeout     = to_q;
  assign o_cycle_count = cyc_q;
  assign o_insn_count  = insn_q;
  assign o_last_pc     = pc_q;

endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: directed bench for run_monitor. Two instances share the
// stimulus: A (32-bit counters, timeout 100) and B (4-bit counters, timeout
// 1000). A behavioural model predicts both; literal checks pin key results.
module tb_run_monitor;
  localparam int unsigned HR   = 4;
  localparam int unsigned SL   = 16;
  localparam int unsigned TO_A = 100;
  localparam int unsigned TO_B = 1000;
`ifdef RUN_MONITOR_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clk, rst_n, start, clear, vld;
  logic [31:0] pc;

  logic [1:0]  a_state, b_state;
  logic        a_done, a_pass, a_to, a_stl, b_done, b_pass, b_to, b_stl;
  logic [31:0] a_cyc, a_insn, a_last, b_last;
  logic [3:0]  b_cyc, b_insn;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  run_monitor #(.PC_W(32), .CNT_W(32), .TIMEOUT_CYCLES(TO_A),
                .STALL_LIMIT(SL), .HALT_REPEAT(HR)) u_a (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_clear(clear),
    .i_insn_vld(vld), .i_pc_debug(pc), .o_state(a_state), .o_done(a_done),
    .o_pass(a_pass), .o_timeout(a_to), .o_stall(a_stl),
    .o_cycle_count(a_cyc), .o_insn_count(a_insn), .o_last_pc(a_last));

  run_monitor #(.PC_W(32), .CNT_W(4), .TIMEOUT_CYCLES(TO_B),
                .STALL_LIMIT(SL), .HALT_REPEAT(HR)) u_b (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_clear(clear),
    .i_insn_vld(vld), .i_pc_debug(pc), .o_state(b_state), .o_done(b_done),
    .o_pass(b_pass), .o_timeout(b_to), .o_stall(b_stl),
    .o_cycle_count(b_cyc), .o_insn_count(b_insn), .o_last_pc(b_last));

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_st   [2];
  longint      m_cyc  [2];
  longint      m_ins  [2];
  logic [31:0] m_last [2];
  bit          m_to   [2];
  bit          m_stl  [2];
  longint      m_nret [2];
  longint      m_idle [2];
  logic [31:0] m_win  [2][HR];
  longint      m_max  [2];
  longint      m_tol  [2];

  initial begin
    m_max[0] = 64'hFFFF_FFFF; m_max[1] = 15;
    m_tol[0] = TO_A;          m_tol[1] = TO_B;
  end

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic m_zero(input int i);
    m_cyc[i] = 0; m_ins[i] = 0; m_last[i] = '0; m_to[i] = 0; m_stl[i] = 0;
    m_nret[i] = 0; m_idle[i] = 0;
    for (int j = 0; j < HR; j++) m_win[i][j] = '0;
  endtask

  task automatic m_step(input int i);
    bit same, halt, tmo, stl;
    if (clear) begin
      m_zero(i); m_st[i] = 0;
    end else if (m_st[i] == 0) begin
      if (start) begin m_zero(i); m_st[i] = 1; end
    end else if (m_st[i] == 1) begin
      m_cyc[i]++;
      if (vld) begin
        m_ins[i]++;
        m_last[i] = pc;
        for (int j = HR - 1; j > 0; j--) m_win[i][j] = m_win[i][j-1];
        m_win[i][0] = pc;
        m_nret[i]++;
        m_idle[i] = 0;
      end else begin
        m_idle[i]++;
      end
      same = 1'b1;
      for (int j = 1; j < HR; j++) if (m_win[i][j] != m_win[i][0]) same = 1'b0;
      halt = vld && (m_nret[i] >= HR) && same;
      tmo  = (m_cyc[i] == m_tol[i]);
      stl  = STALL_EN && (m_idle[i] == SL);
      if (halt)      m_st[i] = 2;
      else if (tmo) begin m_st[i] = 3; m_to[i] = 1; end
      else if (stl) begin m_st[i] = 3; m_stl[i] = 1; end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin m_zero(i); m_st[i] = 0; end
    end else begin
      for (int i = 0; i < 2; i++) m_step(i);
    end
  end

  // Compare both instances against the model every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("A.state",  a_state, m_st[0]);
      chk("A.done",   a_done,  m_st[0] >= 2);
      chk("A.pass",   a_pass,  m_st[0] == 2);
      chk("A.tmo",    a_to,    m_to[0]);
      chk("A.stall",  a_stl,   m_stl[0]);
      chk("A.cycle",  a_cyc,   sat(m_cyc[0], m_max[0]));
      chk("A.insn",   a_insn,  sat(m_ins[0], m_max[0]));
      chk("A.lastpc", a_last,  m_last[0]);
      chk("B.state",  b_state, m_st[1]);
      chk("B.done",   b_done,  m_st[1] >= 2);
      chk("B.pass",   b_pass,  m_st[1] == 2);
      chk("B.tmo",    b_to,    m_to[1]);
      chk("B.stall",  b_stl,   m_stl[1]);
      chk("B.cycle",  b_cyc,   sat(m_cyc[1], m_max[1]));
      chk("B.insn",   b_insn,  sat(m_ins[1], m_max[1]));
      chk("B.lastpc", b_last,  m_last[1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] p);
    vld = 1'b1; pc = p;
    tick();
    vld = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; vld = 1'b0; pc = '0;
    #55;
    rst_n = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst.A.state", a_state, 0);
    chk("rst.A.cycle", a_cyc, 0);
    chk("rst.A.done",  a_done, 0);
    chk("rst.B.insn",  b_insn, 0);

    // Idle after release; retirements in IDLE are ignored
    vld = 1'b1; pc = 32'h5;
    repeat (3) tick();
    vld = 1'b0;
    chk("idle.A.state", a_state, 0);
    chk("idle.A.insn",  a_insn, 0);

    // Self-loop halt
    do_start();
    chk("run.A.state", a_state, 1);
    retire(32'h0); retire(32'h4); retire(32'h8); retire(32'hC);
    repeat (4) retire(32'h10);
    chk("halt.A.state",  a_state, 2);
    chk("halt.A.pass",   a_pass, 1);
    chk("halt.A.insn",   a_insn, 8);
    chk("halt.A.lastpc", a_last, 32'h10);
    chk("halt.A.cycle",  a_cyc, 8);

    // Terminal: retirements and start ignored
    vld = 1'b1; pc = 32'h55; start = 1'b1;
    repeat (3) tick();
    vld = 1'b0; start = 1'b0;
    chk("frz.A.state", a_state, 2);
    chk("frz.A.insn",  a_insn, 8);

    // Clear wins over start
    clear = 1'b1; start = 1'b1; tick(); clear = 1'b0; start = 1'b0;
    chk("clr.A.state", a_state, 0);
    chk("clr.A.insn",  a_insn, 0);

    // Timeout on A; saturation on B
    do_start();
    for (int k = 0; k < 99; k++) retire(32'h100 + 32'(4 * k));
    chk("to99.A.state", a_state, 1);
    chk("to99.A.cycle", a_cyc, 99);
    retire(32'h100 + 32'(4 * 99));
    chk("to.A.state", a_state, 3);
    chk("to.A.tmo",   a_to, 1);
    chk("to.A.stall", a_stl, 0);
    chk("to.A.cycle", a_cyc, 100);
    chk("sat.B.insn", b_insn, 15);
    chk("sat.B.state", b_state, 1);
    for (int k = 0; k < 5; k++) retire(32'h900 + 32'(4 * k));
    chk("sat2.B.insn", b_insn, 15);
    chk("sat2.B.cycle", b_cyc, 15);
    do_clear();
    chk("clr2.B.state", b_state, 0);
    chk("clr2.B.insn",  b_insn, 0);

    // Stall watchdog
    do_start();
    retire(32'h20); retire(32'h24); retire(32'h28);
    repeat (15) tick();
    chk("stl15.A.state", a_state, 1);
    tick();
`ifdef RUN_MONITOR_STALL_EN
    chk("stl.A.state", a_state, 3);
    chk("stl.A.stall", a_stl, 1);
    chk("stl.A.tmo",   a_to, 0);
    chk("stl.A.insn",  a_insn, 3);
`else
    chk("nostl.A.state", a_state, 1);
    chk("nostl.A.stall", a_stl, 0);
    chk("nostl.A.insn",  a_insn, 3);
`endif
    repeat (4) tick();
    do_clear();

    // Halt coinciding with timeout: halt wins
    do_start();
    for (int k = 0; k < 96; k++) retire(32'h1000 + 32'(4 * k));
    repeat (3) retire(32'h40);
    chk("hvt.A.state99", a_state, 1);
    retire(32'h40);
    chk("hvt.A.state", a_state, 2);
    chk("hvt.A.tmo",   a_to, 0);
    chk("hvt.A.cycle", a_cyc, 100);
    do_clear();

    // Asynchronous reset mid-run
    do_start();
    for (int k = 0; k < 40; k++) retire(32'h2000 + 32'(4 * k));
    chk("ar40.A.cycle", a_cyc, 40);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.A.state",  a_state, 0);
    chk("ar.A.cycle",  a_cyc, 0);
    chk("ar.A.insn",   a_insn, 0);
    chk("ar.A.lastpc", a_last, 0);
    chk("ar.A.done",   a_done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arrel.A.state", a_state, 0);
    do_start();
    retire(32'h3000); retire(32'h3004);
    chk("rst2.A.cycle",  a_cyc, 2);
    chk("rst2.A.insn",   a_insn, 2);
    chk("rst2.A.lastpc", a_last, 32'h3004);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
